johnson_step_ctrl: RTL and testbench

- Command-driven sequencer for a WIDTH-bit Johnson (twisted-ring) phase register, such as a stepper-motor or multiphase drive.
- Accepts a move command (direction, step count, step interval) over a valid/ready handshake.
- Advances the Johnson phase one state per step at the programmed rate, then reports completion.
- Sits between a host/register block and the phase outputs.

---
 rtl/johnson_step_ctrl.sv | 109 ++++++++++
 tb/tb_johnson_step_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson phase sequencer: one ring step per programmed interval, done pulse at end of move.
// Optional build macro JSTEP_PAUSE_EN adds a pause input that freezes a running move.
module johnson_step_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_div,
  input  logic              abort,
`ifdef JSTEP_PAUSE_EN
  input  logic              pause,
`endif
  output logic [WIDTH-1:0]  phase,
  output logic              step_pulse,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] remaining
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_phase;
  logic [STEP_W-1:0] r_remaining;
  logic [DIV_W-1:0]  r_presc;
  logic [DIV_W-1:0]  r_div;
  logic              r_dir;

  logic              w_pause;
  logic              w_step;
  logic [WIDTH-2:0]  w_trans;
  logic              w_valid_code;
  logic [WIDTH-1:0]  w_next_phase;

`ifdef JSTEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // A legal Johnson code has at most one boundary between adjacent bits.
  assign w_trans      = r_phase[WIDTH-1:1] ^ r_phase[WIDTH-2:0];
  assign w_valid_code = ((w_trans & (w_trans - 1'b1)) == '0);

  always_comb begin
    w_next_phase = '0;
    if (w_valid_code) begin
      if (r_dir) w_next_phase = {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
      else       w_next_phase = {~r_phase[0], r_phase[WIDTH-1:1]};
    end
  end

  assign w_step     = (r_state == S_RUN) && (r_presc == '0) && !abort && !w_pause;
  assign step_pulse = w_step;
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN) || (r_state == S_DONE);
  assign done       = (r_state == S_DONE);
  assign phase      = r_phase;
  assign remaining  = r_remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_remaining <= '0;
      r_presc     <= '0;
      r_div       <= '0;
      r_dir       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_dir       <= cmd_dir;
            r_div       <= cmd_div;
            r_presc     <= cmd_div;
            r_remaining <= cmd_steps;
            r_state     <= (cmd_steps != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          // Abort beats both a due step and pause; remaining keeps the unissued count.
          if (abort) begin
            r_state <= S_DONE;
          end else if (!w_pause) begin
            if (r_presc != '0) begin
              r_presc <= r_presc - 1'b1;
            end else begin
              r_phase     <= w_next_phase;
              r_remaining <= r_remaining - 1'b1;
              r_presc     <= r_div;
              if (r_remaining == STEP_W'(1)) r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed bench for johnson_step_ctrl: inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_johnson_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = '0;
  logic [7:0] cmd_div = '0;
  logic       abort = 1'b0;
`ifdef JSTEP_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] phase;
  logic       step_pulse;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  johnson_step_ctrl #(.WIDTH(4), .STEP_W(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_div    (cmd_div),
    .abort      (abort),
`ifdef JSTEP_PAUSE_EN
    .pause      (pause),
`endif
    .phase      (phase),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining)
  );

  // Presents a command for one edge; returns 1 time unit after the accept edge.
  task automatic issue(input logic dir, input logic [7:0] steps, input logic [7:0] div);
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_div   = div;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Runs a move until done is seen (bounded); leaves the bench in the cycle after done.
  task automatic run_move(input logic dir, input logic [7:0] steps, input logic [7:0] div,
                          output int pulses, output bit seen_done);
    pulses = 0;
    seen_done = 1'b0;
    issue(dir, steps, div);
    for (int c = 0; c < 2000 && !seen_done; c++) begin
      @(negedge clk);
      if (step_pulse) pulses++;
      if (done) seen_done = 1'b1;
      next_cycle();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (phase !== 4'b0000 || remaining !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_regs: phase=%b remaining=%0d, required phase=0000 remaining=0", phase, remaining);
    end
    n_tests++;
    if ({cmd_ready, busy, done, step_pulse} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/busy/done/pulse=%b, required 1000", {cmd_ready, busy, done, step_pulse});
    end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [4:0] exp_pulse = 5'b00111;
    logic [4:0] exp_done  = 5'b01000;
    logic [4:0] exp_ready = 5'b10000;
    logic [3:0] exp_ph [5] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1110};
    issue(1'b0, 8'd3, 8'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (step_pulse !== exp_pulse[i] || done !== exp_done[i] || cmd_ready !== exp_ready[i] ||
          phase !== exp_ph[i]) begin
        n_fail++;
        $display("FAIL basic_c%0d: pulse=%b done=%b ready=%b phase=%b, required %b %b %b %b",
                 i + 1, step_pulse, done, cmd_ready, phase, exp_pulse[i], exp_done[i], exp_ready[i], exp_ph[i]);
      end
      if (i == 3) begin
        n_tests++;
        if (remaining !== 8'd0) begin
          n_fail++;
          $display("FAIL basic_remaining: got %0d, required 0", remaining);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_div();
    logic ep, eb, ed;
    issue(1'b0, 8'd2, 8'd4);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 5) || (i == 10);
      eb = (i <= 11);
      ed = (i == 11);
      n_tests++;
      if (step_pulse !== ep || busy !== eb || done !== ed) begin
        n_fail++;
        $display("FAIL div_c%0d: pulse=%b busy=%b done=%b, required %b %b %b",
                 i, step_pulse, busy, done, ep, eb, ed);
      end
      if (i == 6) begin
        n_tests++;
        if (remaining !== 8'd1 || phase !== 4'b1111) begin
          n_fail++;
          $display("FAIL div_mid: remaining=%0d phase=%b, required 1 1111", remaining, phase);
        end
      end
      next_cycle();
    end
    n_tests++;
    if (phase !== 4'b0111) begin
      n_fail++;
      $display("FAIL div_end_phase: got %b, required 0111", phase);
    end
  endtask

  task automatic test_wrap();
    int p;
    bit d;
    do_reset();
    run_move(1'b0, 8'd8, 8'd0, p, d);
    n_tests++;
    if (!d || p != 8 || phase !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_fwd8: done_seen=%0d pulses=%0d phase=%b, required 1 8 0000", d, p, phase);
    end
    run_move(1'b1, 8'd1, 8'd0, p, d);
    n_tests++;
    if (!d || p != 1 || phase !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_rev1: done_seen=%0d pulses=%0d phase=%b, required 1 1 0001", d, p, phase);
    end
  endtask

  task automatic test_zero_steps();
    issue(1'b0, 8'd0, 8'd3);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1 || step_pulse !== 1'b0 || phase !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_c1: done=%b busy=%b pulse=%b phase=%b, required 1 1 0 0001",
               done, busy, step_pulse, phase);
    end
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_c2: done=%b ready=%b pulse=%b, required 0 1 0", done, cmd_ready, step_pulse);
    end
    next_cycle();
  endtask

  task automatic test_abort();
    int pulses = 0;
    issue(1'b0, 8'd10, 8'd1);
    for (int i = 1; i <= 10; i++) begin
      abort = (i == 10);
      @(negedge clk);
      if (step_pulse) pulses++;
      if (i == 10) begin
        n_tests++;
        if (step_pulse !== 1'b0 || pulses != 4) begin
          n_fail++;
          $display("FAIL abort_due: pulse=%b total_pulses=%0d, required 0 4", step_pulse, pulses);
        end
      end
      next_cycle();
    end
    abort = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || remaining !== 8'd6 || phase !== 4'b1110 || step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: done=%b remaining=%0d phase=%b pulse=%b, required 1 6 1110 0",
               done, remaining, phase, step_pulse);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_move();
    int dones = 0;
    issue(1'b0, 8'd5, 8'd2);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (phase !== 4'b1111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: phase=%b busy=%b, required 1111 1", phase, busy);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (phase !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || remaining !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_post: phase=%b busy=%b done=%b remaining=%0d, required 0000 0 0 0",
               phase, busy, done, remaining);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || step_pulse) dones++;
      next_cycle();
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: done/pulse seen %0d cycles, required 0", dones);
    end
  endtask

`ifdef JSTEP_PAUSE_EN
  task automatic test_pause();
    logic ep;
    issue(1'b0, 8'd2, 8'd2);
    for (int i = 1; i <= 14; i++) begin
      pause = (i >= 4) && (i <= 10);
      @(negedge clk);
      ep = (i == 3) || (i == 13);
      n_tests++;
      if (step_pulse !== ep || busy !== 1'b1 || done !== (i == 14)) begin
        n_fail++;
        $display("FAIL pause_c%0d: pulse=%b busy=%b done=%b, required %b 1 %b",
                 i, step_pulse, busy, done, ep, (i == 14));
      end
      next_cycle();
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div();
    test_wrap();
    test_zero_steps();
    test_abort();
    test_reset_mid_move();
`ifdef JSTEP_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
